// File: rtl/status_bank_pkg.sv
// Shared field layout and types for the multi-channel status bank.
// Offsets are functions of the channel parameters so every instance agrees on one layout.
// Combinational helpers only; no state.
package status_bank_pkg;

    localparam int SUMMARY_PENDING_OFFSET = 0;
    localparam int SUMMARY_IRQ_EN_OFFSET  = 16;

    typedef struct packed {
        logic err_packet;
        logic err_buffer;
    } ch_flags_t;

    function automatic int buf_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int off_status_id();
        return 0;
    endfunction

    function automatic int off_buffered(input int id_w);
        return id_w;
    endfunction

    function automatic int off_err_buffer(input int id_w, input int depth);
        return id_w + buf_width(depth);
    endfunction

    function automatic int off_err_packet(input int id_w, input int depth);
        return off_err_buffer(id_w, depth) + 1;
    endfunction

    function automatic int off_err_clear(input int id_w, input int depth);
        return off_err_buffer(id_w, depth) + 2;
    endfunction

    function automatic int off_packet_count(input int id_w, input int depth);
        return off_err_buffer(id_w, depth) + 3;
    endfunction

    function automatic logic [31:0] field_mask(input int offset, input int width);
        return ((32'h1 << width) - 32'h1) << offset;
    endfunction

endpackage

// File: rtl/status_id_fifo.sv
// Per-channel circular FIFO of completed packet IDs.
// Latency: push visible on head/count the cycle after the write edge (no fall-through).
// Backpressure: push while full is ignored unless a pop lands in the same cycle; pop on empty is ignored.
module status_id_fifo #(
    parameter int ID_WIDTH = 6,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [ID_WIDTH-1:0] din,
    output logic                full,
    output logic                empty,
    output logic [CNT_W-1:0]    count,
    output logic [ID_WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    occ;
    logic                do_pop;
    logic                do_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & (occ != '0);
    assign do_push = push & ((occ != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // When full, wr_ptr equals rd_ptr, so a push+pop overwrites exactly the slot being popped.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign full  = (occ == CNT_W'(DEPTH));
    assign empty = (occ == '0);
    assign count = occ;
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/status_bank.sv
// Multi-channel status bank: ID FIFOs, sticky error flags, packet counters, register port and irq.
// Latency: register read data one cycle after reg_rd_en; irq one cycle after a flag change.
// Backpressure: none; overflowing IDs are dropped and flagged in ERR_BUFFER.
module status_bank
    import status_bank_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ID_WIDTH    = 6,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 10,
    parameter int ADDR_W      = $clog2((NUM_CH + 1) * 4)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            pkt_valid,
    input  logic [NUM_CH*ID_WIDTH-1:0]   pkt_id,
    input  logic [NUM_CH-1:0]            pkt_err,
    input  logic [NUM_CH-1:0]            id_pop,
    output logic [NUM_CH-1:0]            id_avail,
    output logic [NUM_CH*ID_WIDTH-1:0]   id_head,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic                         reg_rd_en,
    output logic                         reg_rd_valid,
    output logic [31:0]                  reg_rd_data,
    input  logic                         reg_wr_en,
    input  logic [31:0]                  reg_wr_data,
    output logic                         irq
);

    localparam int BUF_W      = buf_width(DEPTH);
    localparam int OFF_ID     = off_status_id();
    localparam int OFF_BUF    = off_buffered(ID_WIDTH);
    localparam int OFF_EBUF   = off_err_buffer(ID_WIDTH, DEPTH);
    localparam int OFF_EPKT   = off_err_packet(ID_WIDTH, DEPTH);
    localparam int OFF_ECLR   = off_err_clear(ID_WIDTH, DEPTH);
    localparam int OFF_CNT    = off_packet_count(ID_WIDTH, DEPTH);
    localparam int WORD_IDX_W = ADDR_W - 2;

    logic [WORD_IDX_W-1:0] word_idx;
    logic                  clr_req;
    logic                  wr_summary;
    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     irq_en;
    logic [31:0]           ch_word [NUM_CH];
    logic [31:0]           summary_word;
    logic [31:0]           rd_mux;
    logic                  unused_ok;

    assign word_idx   = reg_addr[ADDR_W-1:2];
    assign clr_req    = |(reg_wr_data & field_mask(OFF_ECLR, 1));
    assign wr_summary = reg_wr_en && (word_idx == WORD_IDX_W'(NUM_CH));
    assign unused_ok  = ^{reg_wr_data, reg_addr[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ID_WIDTH-1:0]    status_id;
        logic [COUNT_WIDTH-1:0] pkt_cnt;
        ch_flags_t              flags;
        logic [BUF_W-1:0]       occ;
        logic                   fifo_full;
        logic                   fifo_empty;
        logic                   accept;
        logic                   drop;
        logic                   clear;
        logic [31:0]            word;

        assign accept = pkt_valid[c] & (~fifo_full | id_pop[c]);
        assign drop   = pkt_valid[c] & fifo_full & ~id_pop[c];
        assign clear  = reg_wr_en & (word_idx == WORD_IDX_W'(c)) & clr_req;

        status_id_fifo #(
            .ID_WIDTH (ID_WIDTH),
            .DEPTH    (DEPTH),
            .CNT_W    (BUF_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (accept),
            .pop   (id_pop[c]),
            .din   (pkt_id[c*ID_WIDTH +: ID_WIDTH]),
            .full  (fifo_full),
            .empty (fifo_empty),
            .count (occ),
            .head  (id_head[c*ID_WIDTH +: ID_WIDTH])
        );

        // Error events take priority over a same-cycle clear so no event is lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                status_id <= '0;
                pkt_cnt   <= '0;
                flags     <= '0;
            end else begin
                if (accept) begin
                    status_id <= pkt_id[c*ID_WIDTH +: ID_WIDTH];
                    pkt_cnt   <= pkt_cnt + COUNT_WIDTH'(1);
                end
                if (drop)       flags.err_buffer <= 1'b1;
                else if (clear) flags.err_buffer <= 1'b0;
                if (pkt_err[c]) flags.err_packet <= 1'b1;
                else if (clear) flags.err_packet <= 1'b0;
            end
        end

        always_comb begin
            word                          = '0;
            word[OFF_ID +: ID_WIDTH]      = status_id;
            word[OFF_BUF +: BUF_W]        = occ;
            word[OFF_EBUF]                = flags.err_buffer;
            word[OFF_EPKT]                = flags.err_packet;
            word[OFF_CNT +: COUNT_WIDTH]  = pkt_cnt;
        end

        assign ch_word[c]  = word;
        assign pending[c]  = flags.err_buffer | flags.err_packet;
        assign id_avail[c] = ~fifo_empty;
    end

    always_comb begin
        summary_word = '0;
        summary_word[SUMMARY_PENDING_OFFSET +: NUM_CH] = pending;
        summary_word[SUMMARY_IRQ_EN_OFFSET +: NUM_CH]  = irq_en;
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (word_idx == WORD_IDX_W'(c)) rd_mux = ch_word[c];
        end
        if (word_idx == WORD_IDX_W'(NUM_CH)) rd_mux = summary_word;
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= '0;
            irq_en       <= '0;
            irq          <= 1'b0;
        end else begin
            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en) reg_rd_data <= rd_mux;
            if (wr_summary) irq_en <= reg_wr_data[SUMMARY_IRQ_EN_OFFSET +: NUM_CH];
            irq <= |(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_status_bank.sv
// Self-checking bench for status_bank: default instance plus an 8-channel/8-deep/8-bit-ID instance.
// Read results are scoreboarded through queues and compared when reg_rd_valid is sampled.
module tb_status_bank;
    import status_bank_pkg::*;

    localparam int NC = 4, IW = 6, AW = 5;
    localparam int NC8 = 8, IW8 = 8, AW8 = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NC-1:0]     pkt_valid = '0, pkt_err = '0, id_pop = '0, id_avail;
    logic [NC*IW-1:0]  pkt_id = '0, id_head;
    logic [AW-1:0]     reg_addr = '0;
    logic              reg_rd_en = 1'b0, reg_wr_en = 1'b0, reg_rd_valid, irq;
    logic [31:0]       reg_wr_data = '0, reg_rd_data;

    logic [NC8-1:0]     pkt_valid8 = '0, pkt_err8 = '0, id_pop8 = '0, id_avail8;
    logic [NC8*IW8-1:0] pkt_id8 = '0, id_head8;
    logic [AW8-1:0]     reg_addr8 = '0;
    logic               rd_en8 = 1'b0, wr_en8 = 1'b0, rd_valid8, irq8;
    logic [31:0]        wr_data8 = '0, rd_data8;

    status_bank dut (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_id(pkt_id), .pkt_err(pkt_err),
        .id_pop(id_pop), .id_avail(id_avail), .id_head(id_head), .reg_addr(reg_addr),
        .reg_rd_en(reg_rd_en), .reg_rd_valid(reg_rd_valid), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .irq(irq)
    );

    status_bank #(.NUM_CH(NC8), .ID_WIDTH(IW8), .DEPTH(8), .COUNT_WIDTH(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid8), .pkt_id(pkt_id8), .pkt_err(pkt_err8),
        .id_pop(id_pop8), .id_avail(id_avail8), .id_head(id_head8), .reg_addr(reg_addr8),
        .reg_rd_en(rd_en8), .reg_rd_valid(rd_valid8), .reg_rd_data(rd_data8),
        .reg_wr_en(wr_en8), .reg_wr_data(wr_data8), .irq(irq8)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    rd_exp_t rd8_q[$];
    int n_err = 0, n_chk = 0, cyc_cnt = 0;

    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_q.size() != 0 && rd_q[0].due == cyc_cnt) begin
            e = rd_q.pop_front();
            check({e.tag, "_vld"}, 32'(reg_rd_valid), 32'd1);
            check(e.tag, reg_rd_data, e.data);
        end else if (reg_rd_valid) begin
            check("rd_spurious", 32'(reg_rd_valid), 32'd0);
        end
        if (rd8_q.size() != 0 && rd8_q[0].due == cyc_cnt) begin
            e = rd8_q.pop_front();
            check({e.tag, "_vld"}, 32'(rd_valid8), 32'd1);
            check(e.tag, rd_data8, e.data);
        end else if (rd_valid8) begin
            check("rd8_spurious", 32'(rd_valid8), 32'd0);
        end
    end

    // Expected default-layout channel word, built from the documented offsets 0/6/9/10/12.
    function automatic logic [31:0] cw(input int id, input int bufd, input bit eb, input bit ep, input int cnt);
        return (32'(id) & 32'h3F) | ((32'(bufd) & 32'h7) << 6) | (32'(eb) << 9) |
               (32'(ep) << 10) | ((32'(cnt) & 32'h3FF) << 12);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int id, input bit with_pop = 1'b0);
        pkt_valid[ch] = 1'b1;
        pkt_id[ch*IW +: IW] = IW'(id);
        id_pop[ch] = with_pop;
        tick();
        pkt_valid[ch] = 1'b0;
        id_pop[ch] = 1'b0;
    endtask

    task automatic pop(input int ch);
        id_pop[ch] = 1'b1;
        tick();
        id_pop[ch] = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input logic [31:0] exp);
        reg_addr = AW'(addr);
        reg_rd_en = 1'b1;
        rd_q.push_back('{tag: tag, data: exp, due: cyc_cnt + 1});
        tick();
        reg_rd_en = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        reg_addr = AW'(addr);
        reg_wr_en = 1'b1;
        reg_wr_data = data;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic push8(input int ch, input int id);
        pkt_valid8[ch] = 1'b1;
        pkt_id8[ch*IW8 +: IW8] = IW8'(id);
        tick();
        pkt_valid8[ch] = 1'b0;
    endtask

    task automatic rd8(input string tag, input int addr, input logic [31:0] exp);
        reg_addr8 = AW8'(addr);
        rd_en8 = 1'b1;
        rd8_q.push_back('{tag: tag, data: exp, due: cyc_cnt + 1});
        tick();
        rd_en8 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp8;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avail", 32'(id_avail), 32'd0);
        check("rst_head", 32'(id_head), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rd_vld", 32'(reg_rd_valid), 32'd0);
        check("rst_rd_dat", reg_rd_data, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd($sformatf("rst_word%0d", a), a * 4, 32'd0);

        // Basic push and read of channel 1
        push(1, 5);
        push(1, 9);
        check("ch1_avail", 32'(id_avail[1]), 32'd1);
        check("ch1_head", 32'(id_head[IW +: IW]), 32'd5);
        rd("ch1_word", 4, 32'h0000_2089);
        pop(1);
        check("ch1_head_pop1", 32'(id_head[IW +: IW]), 32'd9);
        pop(1);
        check("ch1_avail_pop2", 32'(id_avail[1]), 32'd0);
        check("ch1_head_empty", 32'(id_head[IW +: IW]), 32'd0);
        pop(1);
        rd("ch1_pop_empty", 4, cw(9, 0, 0, 0, 2));
        rd("sum_clean", 16, 32'd0);

        // Overflow on channel 0, then push with same-cycle pop while full
        for (int i = 1; i <= 5; i++) push(0, i);
        check("ch0_head_full", 32'(id_head[0 +: IW]), 32'd1);
        rd("ch0_overflow", 0, cw(4, 4, 1, 0, 4));
        rd("sum_ch0", 16, 32'h0000_0001);
        check("irq_masked", 32'(irq), 32'd0);
        push(0, 6, 1'b1);
        check("ch0_head_pp", 32'(id_head[0 +: IW]), 32'd2);
        rd("ch0_push_pop_full", 0, cw(6, 4, 1, 0, 5));
        wr(0, 32'hFFFF_FFFF);
        rd("ch0_cleared", 0, cw(6, 4, 0, 0, 5));
        wr(20, 32'hFFFF_FFFF);
        wr(28, 32'hFFFF_FFFF);
        rd("sum_oor_write", 16, 32'd0);

        // Read/write collision on the summary word returns the pre-write value
        reg_addr = AW'(16);
        reg_rd_en = 1'b1;
        reg_wr_en = 1'b1;
        reg_wr_data = 32'h0000_0004 << 16;
        rd_q.push_back('{tag: "rdwr_pre", data: 32'd0, due: cyc_cnt + 1});
        tick();
        reg_rd_en = 1'b0;
        reg_wr_en = 1'b0;
        rd("irq_en_rb", 16, 32'h0004_0000);

        // Packet error on channel 2 and irq timing
        pkt_err[2] = 1'b1;
        tick();
        pkt_err[2] = 1'b0;
        check("irq_at_set", 32'(irq), 32'd0);
        tick();
        check("irq_after_set", 32'(irq), 32'd1);
        rd("sum_err2", 16, 32'h0004_0004);
        wr(8, 32'h0000_0800);
        check("irq_at_clear", 32'(irq), 32'd1);
        tick();
        check("irq_after_clear", 32'(irq), 32'd0);
        rd("ch2_cleared", 8, 32'd0);

        // Set/clear collisions: set wins
        pkt_err[2] = 1'b1;
        reg_addr = AW'(8);
        reg_wr_en = 1'b1;
        reg_wr_data = 32'h0000_0800;
        tick();
        pkt_err[2] = 1'b0;
        pkt_valid[0] = 1'b1;
        pkt_id[0 +: IW] = IW'(33);
        reg_addr = AW'(0);
        tick();
        pkt_valid[0] = 1'b0;
        reg_wr_en = 1'b0;
        rd("ch2_collide", 8, cw(0, 0, 0, 1, 0));
        rd("ch0_collide", 0, cw(6, 4, 1, 0, 5));
        wr(8, 32'h0000_0800);
        wr(0, 32'h0000_0800);
        rd("sum_after_collide", 16, 32'h0004_0000);
        for (int i = 0; i < 4; i++) pop(0);
        check("ch0_drained", 32'(id_avail[0]), 32'd0);

        // Counter wrap on channel 3 with concurrent pops
        for (int i = 0; i < 1024; i++) begin
            push(3, i, 1'b1);
            check("wrap_avail", 32'(id_avail[3]), 32'd1);
            check("wrap_head", 32'(id_head[3*IW +: IW]), 32'(i % 64));
        end
        rd("ch3_wrap", 12, cw(63, 1, 0, 0, 0));

        // Wider instance: layout comes from the package functions
        push8(5, 8'hA5);
        push8(5, 8'h3C);
        pkt_err8[5] = 1'b1;
        tick();
        pkt_err8[5] = 1'b0;
        check("w8_head5", 32'(id_head8[5*IW8 +: IW8]), 32'hA5);
        exp8 = 32'h3C | (32'd2 << off_buffered(IW8)) | (32'd1 << off_err_packet(IW8, 8)) |
               (32'd2 << off_packet_count(IW8, 8));
        rd8("w8_ch5", 20, exp8);
        for (int i = 1; i <= 9; i++) push8(6, i);
        exp8 = 32'd8 | (32'd8 << off_buffered(IW8)) | (32'd1 << off_err_buffer(IW8, 8)) |
               (32'd8 << off_packet_count(IW8, 8));
        rd8("w8_ch6_full", 24, exp8);
        rd8("w8_summary", 32, 32'h0000_0060);

        // Asynchronous reset in the middle of a read
        pkt_err[2] = 1'b1;
        tick();
        pkt_err[2] = 1'b0;
        tick();
        check("pre_rst_irq", 32'(irq), 32'd1);
        push(1, 7);
        reg_addr = AW'(4);
        reg_rd_en = 1'b1;
        tick();
        reg_rd_en = 1'b0;
        check("pre_rst_vld", 32'(reg_rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(reg_rd_valid), 32'd0);
        check("mid_rst_dat", reg_rd_data, 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_avail", 32'(id_avail), 32'd0);
        check("mid_rst_head", 32'(id_head), 32'd0);
        check("mid_rst_avail8", 32'(id_avail8), 32'd0);
        check("mid_rst_head8", 32'(id_head8 != '0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_avail", 32'(id_avail), 32'd0);
        rd("post_rst_ch1", 4, 32'd0);
        rd("post_rst_sum", 16, 32'd0);
        rd8("post_rst_w8_ch6", 24, 32'd0);

        repeat (3) tick();
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("rd8_q_drained", 32'(rd8_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
